// File: rtl/frame_ch_pkg.sv
// ============================================================
// frame_ch_pkg: shared defaults and FSM encoding for frame channels
// Rev 1.0
// ============================================================
`default_nettype none

package frame_ch_pkg;

  localparam int DEF_MEM_DATA_BITS = 32;
  localparam int DEF_ADDR_BITS     = 24;
  localparam int DEF_BURST_LEN     = 128;
  localparam int DEF_FIFO_DEPTH    = 512;
  localparam int BLEN_BITS         = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/frame_write_ch_sync_fifo.sv
// ============================================================
// sync_fifo: single-clock FIFO with flush and registered read data
// Rev 1.0
// ============================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == c_depth);
  assign empty_o   = (count_q == '0);
  assign do_push   = wr_en_i && !full_o;
  // A pop on an empty FIFO is ignored so the read pointer never underflows.
  assign do_pop    = rd_en_i && !empty_o;
  assign count_o   = count_q;
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_write_ch.sv
// ============================================================
// frame_write_ch: buffers a word stream and slices each frame into DDR2 write bursts
// Rev 1.0
// ============================================================
`default_nettype none

module frame_write_ch
  import frame_ch_pkg::*;
#(
  parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int BURST_LEN     = DEF_BURST_LEN,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     frame_base_addr,
  input  logic [ADDR_BITS-1:0]     frame_words,
  input  logic                     in_valid,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     overflow,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     wr_burst_req,
  output logic [BLEN_BITS-1:0]     wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_BITS-1:0] c_bl_addr = ADDR_BITS'(BURST_LEN);
  localparam logic [BLEN_BITS-1:0] c_bl_len  = BLEN_BITS'(BURST_LEN);

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] remaining_q, remaining_d;
  logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_BITS-1:0] accept_left_q, accept_left_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 zero_q, zero_d;
  logic                 req_q, req_d;
  logic [BLEN_BITS-1:0] len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 pend_q, pend_d;
  logic [ADDR_BITS-1:0] pend_base_q, pend_base_d;
  logic [ADDR_BITS-1:0] pend_words_q, pend_words_d;

  logic [BLEN_BITS-1:0] blen;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept_now;
  logic [ADDR_BITS-1:0] acc_base;
  logic [ADDR_BITS-1:0] acc_words;
  logic                 word_wanted;
  logic                 push;
  logic                 pop;
  logic                 in_burst;

  assign blen       = (remaining_q >= c_bl_addr) ? c_bl_len : remaining_q[BLEN_BITS-1:0];
  // A direct frame_start in IDLE outranks a restart latched during the previous burst.
  assign accept_now = (state_q == ST_IDLE) && (frame_start || pend_q);
  assign acc_base   = frame_start ? frame_base_addr : pend_base_q;
  assign acc_words  = frame_start ? frame_words : pend_words_q;
  assign in_burst   = (state_q == ST_REQ) || (state_q == ST_WRITE);

  // Words beyond the frame's quota, or outside any frame, are silently dropped.
  assign word_wanted = in_valid && (accept_left_q != '0) && !accept_now;
  assign push        = word_wanted && !fifo_full;
  assign pop         = wr_burst_data_req && in_burst && !fifo_empty;

  sync_fifo #(
    .WIDTH (MEM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (mem_clk),
    .rst       (rst),
    .flush_i   (accept_now),
    .wr_en_i   (push),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_data_o (wr_burst_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    cur_addr_d    = cur_addr_q;
    accept_left_d = accept_left_q;
    overflow_d    = overflow_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    zero_d        = 1'b0;
    req_d         = req_q;
    len_d         = len_q;
    addr_d        = addr_q;
    pend_d        = pend_q;
    pend_base_d   = pend_base_q;
    pend_words_d  = pend_words_q;

    if (zero_q) begin
      done_d = 1'b1;
    end
    if (push) begin
      accept_left_d = accept_left_q - 1'b1;
    end
    if (word_wanted && fifo_full) begin
      overflow_d = 1'b1;
    end
    if (frame_start && (state_q != ST_IDLE)) begin
      pend_d       = 1'b1;
      pend_base_d  = frame_base_addr;
      pend_words_d = frame_words;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_now) begin
          cur_addr_d    = acc_base;
          remaining_d   = acc_words;
          accept_left_d = acc_words;
          overflow_d    = 1'b0;
          pend_d        = 1'b0;
          busy_d        = (acc_words != '0);
          zero_d        = (acc_words == '0);
        end else if ((remaining_q != '0) && (32'(fifo_count) >= 32'(blen))) begin
          req_d   = 1'b1;
          len_d   = blen;
          addr_d  = cur_addr_q;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_burst_data_req) begin
          req_d   = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_burst_finish) begin
          cur_addr_d  = cur_addr_q + ADDR_BITS'(len_q);
          remaining_d = remaining_q - ADDR_BITS'(len_q);
          state_d     = ST_IDLE;
          // A frame superseded by a restart never reports completion.
          if ((remaining_q == ADDR_BITS'(len_q)) && !pend_q && !frame_start) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      cur_addr_q    <= '0;
      accept_left_q <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      zero_q        <= 1'b0;
      req_q         <= 1'b0;
      len_q         <= '0;
      addr_q        <= '0;
      pend_q        <= 1'b0;
      pend_base_q   <= '0;
      pend_words_q  <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      cur_addr_q    <= cur_addr_d;
      accept_left_q <= accept_left_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      zero_q        <= zero_d;
      req_q         <= req_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      pend_q        <= pend_d;
      pend_base_q   <= pend_base_d;
      pend_words_q  <= pend_words_d;
    end
  end

  assign overflow      = overflow_q;
  assign frame_done    = done_q;
  assign busy          = busy_q;
  assign wr_burst_req  = req_q;
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_write_ch.sv
// ============================================================
// tb_frame_write_ch: bench for frame_write_ch with a DDR2 controller responder
// Rev 1.0
// ============================================================
`default_nettype none

module tb_frame_write_ch;

  localparam int BL = 128;

  logic        mem_clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [23:0] frame_base_addr;
  logic [23:0] frame_words;
  logic        in_valid;
  logic [31:0] in_data;
  logic        overflow;
  logic        frame_done;
  logic        busy;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish;

  frame_write_ch #(
    .MEM_DATA_BITS (32),
    .ADDR_BITS     (24),
    .BURST_LEN     (BL),
    .FIFO_DEPTH    (512)
  ) dut (
    .mem_clk           (mem_clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .frame_base_addr   (frame_base_addr),
    .frame_words       (frame_words),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .overflow          (overflow),
    .frame_done        (frame_done),
    .busy              (busy),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_data_req (wr_burst_data_req),
    .wr_burst_data     (wr_burst_data),
    .wr_burst_finish   (wr_burst_finish)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [23:0] bq_addr[$];
  int          bq_len[$];
  logic [31:0] dq[$];
  logic [31:0] stream[$];
  int          bursts_done;
  int          fin_cyc;
  int          done_cnt;
  int          done_cyc;
  int          start_cyc;
  bit          busy_seen;
  bit          ctrl_hold;
  bit          stall_en;
  bit          gap_en;

  typedef struct {
    logic [23:0] base;
    int          words;
    bit          gap;
    bit          stall;
    int          exp_nb;
    int          exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge mem_clk);
    cyc++;
  end

  initial forever begin
    @(negedge mem_clk);
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  // Controller responder: grabs a request, streams data_req, captures data one cycle later.
  int          c_n, c_issued, c_got;
  bit          c_prev, c_bad;
  logic [23:0] c_a0;
  logic [9:0]  c_l0;

  initial begin
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!ctrl_hold && wr_burst_req === 1'b1 && rst === 1'b0) begin
        c_a0 = wr_burst_addr;
        c_l0 = wr_burst_len;
        c_n  = int'(wr_burst_len);
        bq_addr.push_back(c_a0);
        bq_len.push_back(c_n);
        c_issued = 0;
        c_got    = 0;
        c_prev   = 1'b0;
        c_bad    = 1'b0;
        while (c_got < c_n) begin
          if (c_prev) begin
            dq.push_back(wr_burst_data);
            c_got++;
          end
          if (c_issued == 0) begin
            if (wr_burst_req !== 1'b1 || wr_burst_addr !== c_a0 || wr_burst_len !== c_l0) c_bad = 1'b1;
          end else if (wr_burst_req !== 1'b0) begin
            c_bad = 1'b1;
          end
          if (c_issued < c_n && (!stall_en || $urandom_range(0, 3) != 0)) begin
            wr_burst_data_req = 1'b1;
            c_issued++;
            c_prev = 1'b1;
          end else begin
            wr_burst_data_req = 1'b0;
            c_prev = 1'b0;
          end
          if (c_got < c_n) @(negedge mem_clk);
        end
        wr_burst_data_req = 1'b0;
        chk("req_handshake", c_bad, 0);
        wr_burst_finish = 1'b1;
        fin_cyc = cyc;
        bursts_done++;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
      end
    end
  end

  task automatic clear_log();
    bq_addr.delete();
    bq_len.delete();
    dq.delete();
    stream.delete();
    bursts_done = 0;
    done_cnt    = 0;
    busy_seen   = 1'b0;
  endtask

  task automatic pulse_start(input logic [23:0] base, input int words);
    @(negedge mem_clk);
    frame_start     = 1'b1;
    frame_base_addr = base;
    frame_words     = 24'(words);
    start_cyc       = cyc;
    @(negedge mem_clk);
    frame_start     = 1'b0;
    frame_base_addr = 24'($urandom);
    frame_words     = 24'($urandom);
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (done_cnt == 0 && w < 20000) begin
      @(negedge mem_clk);
      w++;
    end
    chk(name, done_cnt != 0, 1);
  endtask

  // Reference: burst k covers words [k*BL, k*BL+len) at (base + k*BL) mod 2^24.
  task automatic run_frame(input logic [23:0] base, input int words, input int exp_nb,
                           input int exp_last);
    int i;
    int nb;
    int el;
    int bad;
    logic [23:0] ea;
    clear_log();
    pulse_start(base, words);
    chk("busy_after_start", busy, (words != 0) ? 1 : 0);
    i = 0;
    while (i < words + 3) begin
      if (gap_en && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = $urandom;
        if (i < words) stream.push_back(in_data);
        i++;
      end
      @(negedge mem_clk);
    end
    in_valid = 1'b0;
    wait_done("done_timeout");
    repeat (4) @(negedge mem_clk);
    nb = bq_addr.size();
    chk("burst_count", nb, exp_nb);
    for (int k = 0; k < nb && k < exp_nb; k++) begin
      ea = 24'((int'(base) + k * BL) % (1 << 24));
      el = (words - k * BL < BL) ? words - k * BL : BL;
      chk("burst_addr", bq_addr[k], ea);
      chk("burst_len", bq_len[k], el);
    end
    if (nb > 0) chk("last_len", bq_len[nb-1], exp_last);
    bad = 0;
    for (int j = 0; j < words; j++) begin
      if (j >= dq.size() || dq[j] !== stream[j]) bad++;
    end
    chk("data_errors", bad, 0);
    chk("data_count", dq.size(), words);
    chk("done_pulses", done_cnt, 1);
    if (words == 0) begin
      chk("done_latency_zero", done_cyc - start_cyc, 2);
      chk("busy_zero_frame", busy_seen, 0);
    end else begin
      chk("done_after_finish", done_cyc - fin_cyc, 1);
    end
    chk("overflow_clean", overflow, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int w;
    int words;
    vecs[0] = '{24'h000100, 256, 1'b0, 1'b0, 2, 128};
    vecs[1] = '{24'h000000, 300, 1'b1, 1'b1, 3, 44};
    vecs[2] = '{24'hFFFFC0, 256, 1'b0, 1'b1, 2, 128};
    vecs[3] = '{24'h123456, 1,   1'b1, 1'b0, 1, 1};
    vecs[4] = '{24'h000800, 128, 1'b1, 1'b1, 1, 128};
    vecs[5] = '{24'h000010, 129, 1'b0, 1'b0, 2, 1};
    vecs[6] = '{24'h000abc, 0,   1'b0, 1'b0, 0, 0};

    rst = 1'b1;
    frame_start = 1'b0;
    frame_base_addr = '0;
    frame_words = '0;
    in_valid = 1'b0;
    in_data = '0;
    ctrl_hold = 1'b1;
    stall_en = 1'b0;
    gap_en = 1'b0;
    repeat (3) @(negedge mem_clk);
    chk("rst_req", wr_burst_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_len", wr_burst_len, 0);
    chk("rst_addr", wr_burst_addr, 0);
    rst = 1'b0;
    ctrl_hold = 1'b0;

    for (int v = 0; v < 7; v++) begin
      gap_en   = vecs[v].gap;
      stall_en = vecs[v].stall;
      run_frame(vecs[v].base, vecs[v].words, vecs[v].exp_nb, vecs[v].exp_last);
    end

    for (int r = 0; r < 6; r++) begin
      gap_en   = 1'($urandom);
      stall_en = 1'($urandom);
      words    = $urandom_range(1, 400);
      run_frame(24'($urandom), words, (words + BL - 1) / BL, words - ((words - 1) / BL) * BL);
    end

    // Restart during WRITE of the first burst.
    gap_en = 1'b0;
    stall_en = 1'b0;
    clear_log();
    pulse_start(24'h000100, 256);
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      @(negedge mem_clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (dq.size() < 10 && w < 2000) begin
      @(negedge mem_clk);
      w++;
    end
    chk("restart_reach_write", dq.size() >= 10, 1);
    pulse_start(24'h002000, 128);
    w = 0;
    while (bursts_done < 1 && w < 2000) begin
      @(negedge mem_clk);
      w++;
    end
    repeat (3) @(negedge mem_clk);
    chk("restart_no_old_done", done_cnt, 0);
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000 + 32'(i);
      @(negedge mem_clk);
    end
    in_valid = 1'b0;
    wait_done("restart_done_timeout");
    repeat (4) @(negedge mem_clk);
    chk("restart_bursts", bq_addr.size(), 2);
    if (bq_addr.size() >= 2) begin
      chk("restart_addr0", bq_addr[0], 24'h000100);
      chk("restart_addr1", bq_addr[1], 24'h002000);
      chk("restart_len1", bq_len[1], 128);
    end
    w = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= dq.size() || dq[i] !== ((i < 128) ? 32'(i) : 32'hA000 + 32'(i - 128))) w++;
    end
    chk("restart_data_errors", w, 0);
    chk("restart_done_pulses", done_cnt, 1);

    // Overflow with a stalled controller, then reset while the next request is pending.
    ctrl_hold = 1'b1;
    clear_log();
    pulse_start(24'h000000, 1024);
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      @(negedge mem_clk);
      if (i == 511) chk("overflow_at_512", overflow, 0);
      if (i == 512) chk("overflow_at_513", overflow, 1);
    end
    in_valid = 1'b0;
    ctrl_hold = 1'b0;
    w = 0;
    while (dq.size() < 1 && w < 2000) begin
      @(negedge mem_clk);
      w++;
    end
    ctrl_hold = 1'b1;
    w = 0;
    while (bursts_done < 1 && w < 2000) begin
      @(negedge mem_clk);
      w++;
    end
    chk("ovf_burst_count", bursts_done, 1);
    w = 0;
    for (int i = 0; i < 128; i++) begin
      if (i >= dq.size() || dq[i] !== 32'(i)) w++;
    end
    chk("ovf_first_burst_data", w, 0);
    w = 0;
    while (wr_burst_req !== 1'b1 && w < 100) begin
      @(negedge mem_clk);
      w++;
    end
    chk("pre_rst_req", wr_burst_req, 1);
    chk("pre_rst_overflow", overflow, 1);
    rst = 1'b1;
    @(negedge mem_clk);
    rst = 1'b0;
    chk("rst_req_req", wr_burst_req, 0);
    chk("rst_req_busy", busy, 0);
    chk("rst_req_overflow", overflow, 0);
    chk("rst_req_done", frame_done, 0);
    ctrl_hold = 1'b0;
    run_frame(24'h000300, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
